// File: rtl/bus_arbiter_if.sv
// Bundles the two requester ports and the memory-side port of the arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
// Widths follow ADDR_W / DATA_W and must match the arbiter instance.
interface bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // requester 0 (core)
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [1:0]        m0_size;
  logic              m0_grant;
  logic              m0_rvalid;
  logic              m0_err;
  logic [DATA_W-1:0] m0_rdata;
  // requester 1 (loader/debug)
  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [1:0]        m1_size;
  logic              m1_grant;
  logic              m1_rvalid;
  logic              m1_err;
  logic [DATA_W-1:0] m1_rdata;
  // memory side
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [1:0]        mem_size;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              busy;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_size,
    output m0_grant, m0_rvalid, m0_err, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_size,
    output m1_grant, m1_rvalid, m1_err, m1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_size,
    input  mem_rdata, mem_ready,
    output busy
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_size,
    input  m0_grant, m0_rvalid, m0_err, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_size,
    input  m1_grant, m1_rvalid, m1_err, m1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_size,
    output mem_rdata, mem_ready,
    input  busy
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-requester round-robin arbiter onto a single memory port, with access timeout.
// Latency: grant in the first ACCESS cycle, rvalid one cycle after mem_ready; 3 cycles minimum per transaction.
// Backpressure: requests are sampled only in IDLE; mem_ready stalls ACCESS up to TIMEOUT cycles, then aborts with err.
module bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic       clk,
  input logic       rst,
  bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t     state;
  logic       owner;
  logic       last_owner;
  logic [7:0] cnt;
  logic       pick;

  // Winner of this cycle's requests: a lone requester wins, a tie goes to whoever did not own last.
  always_comb begin
    pick = 1'b0;
    if (bus.m0_req && bus.m1_req) pick = ~last_owner;
    else if (bus.m1_req)          pick = 1'b1;
  end

  // Arbitration FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= 1'b0;
      last_owner    <= 1'b1;
      cnt           <= 8'd0;
      bus.busy      <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= {ADDR_W{1'b0}};
      bus.mem_wdata <= {DATA_W{1'b0}};
      bus.mem_size  <= 2'd0;
      bus.m0_grant  <= 1'b0;
      bus.m1_grant  <= 1'b0;
      bus.m0_rvalid <= 1'b0;
      bus.m1_rvalid <= 1'b0;
      bus.m0_err    <= 1'b0;
      bus.m1_err    <= 1'b0;
      bus.m0_rdata  <= {DATA_W{1'b0}};
      bus.m1_rdata  <= {DATA_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (bus.m0_req || bus.m1_req) begin
            owner         <= pick;
            last_owner    <= pick;
            cnt           <= 8'd0;
            bus.busy      <= 1'b1;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= pick ? bus.m1_we    : bus.m0_we;
            bus.mem_addr  <= pick ? bus.m1_addr  : bus.m0_addr;
            bus.mem_wdata <= pick ? bus.m1_wdata : bus.m0_wdata;
            bus.mem_size  <= pick ? bus.m1_size  : bus.m0_size;
            bus.m0_grant  <= ~pick;
            bus.m1_grant  <= pick;
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          bus.m0_grant <= 1'b0;
          bus.m1_grant <= 1'b0;
          // A ready in the last counted cycle still completes normally.
          if (bus.mem_ready) begin
            if (owner) bus.m1_rdata <= bus.mem_rdata;
            else       bus.m0_rdata <= bus.mem_rdata;
            bus.m0_rvalid <= ~owner;
            bus.m1_rvalid <= owner;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            state         <= RESP;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            if (owner) bus.m1_rdata <= {DATA_W{1'b0}};
            else       bus.m0_rdata <= {DATA_W{1'b0}};
            bus.m0_rvalid <= ~owner;
            bus.m1_rvalid <= owner;
            bus.m0_err    <= ~owner;
            bus.m1_err    <= owner;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            state         <= RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          bus.m0_rvalid <= 1'b0;
          bus.m1_rvalid <= 1'b0;
          bus.m0_err    <= 1'b0;
          bus.m1_err    <= 1'b0;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: transaction-level model compared every cycle, plus literal pins.
// Outputs sampled on the falling edge; stimulus driven 1 time unit after the rising edge.
// All waits are fixed cycle counts, so the run always terminates.
module tb_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit          mdl_valid = 1'b0;
  bit          m_active, m_resp, m_owner, m_last, m_err;
  int          m_age;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [1:0]    m_size;
  logic [DW-1:0] m_rdata [2];
  int            cyc = 0;

  function automatic bit choose(input bit r0, input bit r1, input bit last);
    if (r0 && r1) return !last;
    return r1;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      mdl_valid  <= 1'b1;
      m_active   <= 1'b0;
      m_resp     <= 1'b0;
      m_owner    <= 1'b0;
      m_last     <= 1'b1;
      m_err      <= 1'b0;
      m_age      <= 0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_size     <= '0;
      m_rdata[0] <= '0;
      m_rdata[1] <= '0;
    end else if (m_resp) begin
      m_resp <= 1'b0;
    end else if (m_active) begin
      if (bus.mem_ready) begin
        m_rdata[m_owner] <= bus.mem_rdata;
        m_err <= 1'b0; m_resp <= 1'b1; m_active <= 1'b0;
      end else if (m_age + 1 == TO) begin
        m_rdata[m_owner] <= '0;
        m_err <= 1'b1; m_resp <= 1'b1; m_active <= 1'b0;
      end else begin
        m_age <= m_age + 1;
      end
    end else if (bus.m0_req || bus.m1_req) begin
      m_owner  <= choose(bus.m0_req, bus.m1_req, m_last);
      m_last   <= choose(bus.m0_req, bus.m1_req, m_last);
      if (choose(bus.m0_req, bus.m1_req, m_last)) begin
        m_we <= bus.m1_we; m_addr <= bus.m1_addr; m_wdata <= bus.m1_wdata; m_size <= bus.m1_size;
      end else begin
        m_we <= bus.m0_we; m_addr <= bus.m0_addr; m_wdata <= bus.m0_wdata; m_size <= bus.m0_size;
      end
      m_active <= 1'b1;
      m_age    <= 0;
    end
  end

  // ---------------- event logs for literal pins ----------------
  int g_who [$];
  int g_cyc [$];
  int rv_cnt [2];
  int rv_cyc [2];
  bit rv_err [2];
  int en_cnt;
  int we_cnt;

  task automatic clear_logs();
    g_who.delete(); g_cyc.delete();
    rv_cnt[0] = 0; rv_cnt[1] = 0; rv_cyc[0] = 0; rv_cyc[1] = 0;
    rv_err[0] = 1'b0; rv_err[1] = 1'b0;
    en_cnt = 0; we_cnt = 0;
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (mdl_valid) begin
      chk("busy",      bus.busy,      m_active || m_resp);
      chk("mem_en",    bus.mem_en,    m_active);
      chk("mem_we",    bus.mem_we,    m_active && m_we);
      chk("mem_addr",  bus.mem_addr,  m_addr);
      chk("mem_wdata", bus.mem_wdata, m_wdata);
      chk("mem_size",  bus.mem_size,  m_size);
      chk("m0_grant",  bus.m0_grant,  m_active && m_age == 0 && !m_owner);
      chk("m1_grant",  bus.m1_grant,  m_active && m_age == 0 && m_owner);
      chk("m0_rvalid", bus.m0_rvalid, m_resp && !m_owner);
      chk("m1_rvalid", bus.m1_rvalid, m_resp && m_owner);
      chk("m0_err",    bus.m0_err,    m_resp && !m_owner && m_err);
      chk("m1_err",    bus.m1_err,    m_resp && m_owner && m_err);
      chk("m0_rdata",  bus.m0_rdata,  m_rdata[0]);
      chk("m1_rdata",  bus.m1_rdata,  m_rdata[1]);
    end
    if (bus.m0_grant === 1'b1) begin g_who.push_back(0); g_cyc.push_back(cyc); end
    if (bus.m1_grant === 1'b1) begin g_who.push_back(1); g_cyc.push_back(cyc); end
    if (bus.m0_rvalid === 1'b1) begin rv_cnt[0]++; rv_cyc[0] = cyc; rv_err[0] = bus.m0_err; end
    if (bus.m1_rvalid === 1'b1) begin rv_cnt[1]++; rv_cyc[1] = cyc; rv_err[1] = bus.m1_err; end
    if (bus.mem_en === 1'b1) en_cnt++;
    if (bus.mem_we === 1'b1) we_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    clear_logs();
  endtask

  initial begin
    rst = 1'b1;
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_size = 2'd0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_size = 2'd0;
    bus.mem_ready = 0; bus.mem_rdata = '0;
    clear_logs();
    do_reset();
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_mem_en", bus.mem_en, 1'b0);

    // single read by m0, memory ready immediately
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h100; bus.m0_size = 2'd2;
    bus.mem_ready = 1; bus.mem_rdata = 32'hDEADBEEF;
    step(1);
    bus.m0_req = 0;
    step(3);
    chk("t1_grants", g_who.size(), 1);
    chk("t1_grant_who", g_who[0], 0);
    chk("t1_rvalid_lat", rv_cyc[0] - g_cyc[0], 1);
    chk("t1_rdata", bus.m0_rdata, 32'hDEADBEEF);
    chk("t1_err", rv_err[0], 1'b0);
    chk("t1_rvalid_cnt", rv_cnt[0], 1);

    // both requesters held: alternating grants 3 cycles apart
    do_reset();
    bus.m0_req = 1; bus.m1_req = 1; bus.m1_addr = 32'h180; bus.mem_ready = 1;
    bus.mem_rdata = 32'h0BADF00D;
    step(12);
    bus.m0_req = 0; bus.m1_req = 0;
    step(3);
    chk("t2_grants", g_who.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_grant_order", g_who[i], i % 2);
      if (i > 0) chk("t2_spacing", g_cyc[i] - g_cyc[i-1], 3);
    end

    // m1 write with memory ready delayed 5 cycles
    do_reset();
    bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 32'h200; bus.m1_wdata = 32'h12345678;
    bus.m1_size = 2'd2; bus.mem_ready = 0; bus.mem_rdata = 32'hCAFEF00D;
    step(1);
    bus.m1_req = 0;
    step(5);
    bus.mem_ready = 1;
    step(1);
    bus.mem_ready = 0;
    step(3);
    chk("t3_en_cycles", en_cnt, 6);
    chk("t3_we_cycles", we_cnt, 6);
    chk("t3_rvalid_cnt", rv_cnt[1], 1);
    chk("t3_err", rv_err[1], 1'b0);
    chk("t3_rdata", bus.m1_rdata, 32'hCAFEF00D);
    chk("t3_m0_rvalid_cnt", rv_cnt[0], 0);
    bus.m1_we = 0;

    // ready in the 16th ACCESS cycle beats the timeout
    do_reset();
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h300; bus.mem_ready = 0;
    bus.mem_rdata = 32'h55AA55AA;
    step(1);
    bus.m0_req = 0;
    step(15);
    bus.mem_ready = 1;
    step(1);
    bus.mem_ready = 0;
    step(3);
    chk("t4a_en_cycles", en_cnt, 16);
    chk("t4a_err", rv_err[0], 1'b0);
    chk("t4a_rdata", bus.m0_rdata, 32'h55AA55AA);
    chk("t4a_lat", rv_cyc[0] - g_cyc[0], 16);

    // memory never ready: abort after 16 ACCESS cycles
    clear_logs();
    bus.m0_req = 1;
    step(1);
    bus.m0_req = 0;
    step(20);
    chk("t4b_en_cycles", en_cnt, 16);
    chk("t4b_rvalid_cnt", rv_cnt[0], 1);
    chk("t4b_err", rv_err[0], 1'b1);
    chk("t4b_rdata", bus.m0_rdata, 32'h0);
    chk("t4b_lat", rv_cyc[0] - g_cyc[0], 16);

    // reset in the third ACCESS cycle aborts; following tie goes to m0
    do_reset();
    bus.m1_req = 1; bus.m1_addr = 32'h400; bus.mem_ready = 0;
    step(1);
    step(2);
    rst = 1'b1;
    step(1);
    chk("t5_mem_en_after_rst", bus.mem_en, 1'b0);
    chk("t5_busy_after_rst", bus.busy, 1'b0);
    rst = 1'b0;
    bus.m0_req = 1;
    step(1);
    bus.m0_req = 0; bus.m1_req = 0; bus.mem_ready = 1;
    step(4);
    bus.mem_ready = 0;
    chk("t5_m1_rvalid_cnt", rv_cnt[1], 0);
    chk("t5_grants", g_who.size(), 2);
    chk("t5_tie_winner", g_who[1], 0);
    chk("t5_m0_rvalid_cnt", rv_cnt[0], 1);

    // mem_ready while idle with no requests is ignored
    do_reset();
    bus.mem_ready = 1; bus.mem_rdata = 32'hFFFFFFFF;
    step(5);
    bus.mem_ready = 0;
    chk("t6_busy", bus.busy, 1'b0);
    chk("t6_en_cycles", en_cnt, 0);
    chk("t6_rvalid", rv_cnt[0] + rv_cnt[1], 0);
    chk("t6_m0_rdata", bus.m0_rdata, 32'h0);
    chk("t6_m1_rdata", bus.m1_rdata, 32'h0);
    chk("t6_grants", g_who.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
